pico_trace_buf: RTL and testbench

PICO_TRACE_BUF -- requirements
Module: pico_trace_buf

---
 rtl/pico_trace_buf.sv | 102 ++++++++++
 tb/tb_pico_trace_buf.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pico_trace_buf.sv
// Trace capture FIFO for a small CPU: records trace words while capturing,
// freezes on a trap, then reports done once the consumer has drained everything.
module pico_trace_buf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 36
) (
  input  logic                     clk,
  input  logic                     PoR_rst_n,
  input  logic                     enable,
  input  logic                     trace_valid,
  input  logic [DATA_W-1:0]        trace_data,
  input  logic                     trap,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              overflow_cnt,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   level_nxt;
  logic          pop, cap, push, drop;

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign pop  = out_valid & out_ready & ~flush;
  assign cap  = (state == S_CAPTURE) & trace_valid & ~flush;
  assign push = cap & ((level != LVL_FULL) | pop);
  assign drop = cap & ~push;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LVL_ONE;
    else if (pop && !push) level_nxt = level - LVL_ONE;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = enable ? S_CAPTURE : S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (enable) state_nxt = S_CAPTURE;
        S_CAPTURE: begin
          if (trap)         state_nxt = S_DRAIN;
          else if (!enable) state_nxt = S_IDLE;
        end
        // Looks at post-pop occupancy so done rises on the last pop's edge.
        S_DRAIN:   if (level_nxt == '0) state_nxt = S_DONE;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      state        <= S_IDLE;
      done         <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      overflow_cnt <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == S_DONE);
      if (flush) begin
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        level        <= '0;
        overflow_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        level <= level_nxt;
        if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trace_data;
  end

endmodule

// File: tb/tb_pico_trace_buf.sv
// Bench for pico_trace_buf: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pico_trace_buf;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 36;

  logic              clk = 1'b0;
  logic              PoR_rst_n;
  logic              enable, trace_valid, trap, flush, out_ready;
  logic [DATA_W-1:0] trace_data;
  logic              out_valid, done;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]       overflow_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pico_trace_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .PoR_rst_n(PoR_rst_n), .enable(enable), .trace_valid(trace_valid),
    .trace_data(trace_data), .trap(trap), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .level(level),
    .overflow_cnt(overflow_cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain queue plus the phase of the trace session.
  typedef enum {M_IDLE, M_CAPTURE, M_DRAIN, M_DONE} m_phase_t;
  logic [DATA_W-1:0] q[$];
  m_phase_t          m_phase;
  int                m_ovf;

  always @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      q.delete();
      m_phase = M_IDLE;
      m_ovf   = 0;
    end else if (flush) begin
      q.delete();
      m_ovf   = 0;
      m_phase = enable ? M_CAPTURE : M_IDLE;
    end else begin
      bit taken, wants;
      taken = (q.size() > 0) && out_ready;
      wants = (m_phase == M_CAPTURE) && trace_valid;
      if (wants && !(q.size() < DEPTH || taken)) begin
        if (m_ovf < 65535) m_ovf++;
      end
      if (taken) void'(q.pop_front());
      if (wants && q.size() < DEPTH) q.push_back(trace_data);
      case (m_phase)
        M_IDLE:    if (enable) m_phase = M_CAPTURE;
        M_CAPTURE: if (trap) m_phase = M_DRAIN; else if (!enable) m_phase = M_IDLE;
        M_DRAIN:   if (q.size() == 0) m_phase = M_DONE;
        default:   ;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("m_level", level, q.size());
    chk("m_out_valid", out_valid, q.size() != 0);
    chk("m_overflow", overflow_cnt, m_ovf);
    chk("m_done", done, m_phase == M_DONE);
    if (q.size() != 0) chk("m_out_data", out_data, q[0]);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    PoR_rst_n = 1'b0; enable = 1'b0; trace_valid = 1'b0; trap = 1'b0;
    flush = 1'b0; out_ready = 1'b0; trace_data = '0;
    repeat (2) cyc();
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow_cnt, 0);
    PoR_rst_n = 1'b1;

    // Three words, then drain in order.
    enable = 1'b1; cyc();
    trace_valid = 1'b1;
    trace_data = 36'hA_0000_000A; cyc();
    trace_data = 36'hB_0000_000B; cyc();
    trace_data = 36'hC_0000_000C; cyc();
    trace_valid = 1'b0;
    chk("abc_level", level, 3);
    chk("abc_head", out_data, 36'hA_0000_000A);
    out_ready = 1'b1;
    chk("abc_pop0", out_data, 36'hA_0000_000A); cyc();
    chk("abc_pop1", out_data, 36'hB_0000_000B); cyc();
    chk("abc_pop2", out_data, 36'hC_0000_000C); cyc();
    out_ready = 1'b0;
    chk("abc_empty_level", level, 0);
    chk("abc_empty_valid", out_valid, 0);

    // Overfill: 20 words into 16 entries.
    for (int i = 0; i < 20; i++) begin
      trace_valid = 1'b1; trace_data = 36'h100 + 36'(i); cyc();
    end
    trace_valid = 1'b0;
    chk("ovf_level", level, 16);
    chk("ovf_cnt", overflow_cnt, 4);
    chk("ovf_head", out_data, 36'h100);

    // Full with simultaneous push and pop: no drops, order contiguous.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("full_pp_head", out_data, 36'h100 + 36'(i));
      trace_valid = 1'b1; trace_data = 36'h200 + 36'(i); cyc();
    end
    trace_valid = 1'b0; out_ready = 1'b0;
    chk("full_pp_level", level, 16);
    chk("full_pp_cnt", overflow_cnt, 4);
    chk("full_pp_next", out_data, 36'h105);

    // Trap with a word in the same cycle, drain to done.
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_level", level, 0);
    trace_valid = 1'b1;
    trace_data = 36'h300; cyc();
    trace_data = 36'h301; cyc();
    trace_data = 36'h302; trap = 1'b1; cyc();
    trap = 1'b0;
    chk("trap_level", level, 3);
    chk("trap_done", done, 0);
    trace_data = 36'h3FF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_word", out_data, 36'h300 + 36'(i)); cyc();
    end
    chk("drain_done", done, 1);
    chk("drain_level", level, 0);
    repeat (2) cyc();
    chk("done_ignores_level", level, 0);
    chk("done_hold", done, 1);
    trace_valid = 1'b0; out_ready = 1'b0;

    // Done with overflow_cnt=5, then flush with enable.
    flush = 1'b1; cyc(); flush = 1'b0;
    for (int i = 0; i < 21; i++) begin
      trace_valid = 1'b1; trace_data = 36'h400 + 36'(i); cyc();
    end
    trace_valid = 1'b0;
    chk("pre_done_cnt", overflow_cnt, 5);
    trap = 1'b1; cyc(); trap = 1'b0;
    out_ready = 1'b1;
    repeat (16) cyc();
    out_ready = 1'b0;
    chk("done5_done", done, 1);
    chk("done5_cnt", overflow_cnt, 5);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("reflush_level", level, 0);
    chk("reflush_cnt", overflow_cnt, 0);
    chk("reflush_done", done, 0);
    trace_valid = 1'b1; trace_data = 36'h500; cyc(); trace_valid = 1'b0;
    chk("reflush_capture", level, 1);

    // Asynchronous reset mid-capture with seven words stored.
    for (int i = 1; i < 7; i++) begin
      trace_valid = 1'b1; trace_data = 36'h500 + 36'(i); cyc();
    end
    trace_valid = 1'b0;
    chk("pre_rst_level", level, 7);
    #1 PoR_rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_cnt", overflow_cnt, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_done", done, 0);
    cyc();
    PoR_rst_n = 1'b1;
    cyc();
    trace_valid = 1'b1; trace_data = 36'h600; cyc(); trace_valid = 1'b0;
    chk("post_rst_level", level, 1);
    chk("post_rst_head", out_data, 36'h600);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
